// File: rtl/core_fpu_ctrl.sv
// Sequencer between the execute stage and the four AXI-Stream FP units
// (ADDSUB, MUL, DIV, COMP): issues operands/opcode, waits for the unit's
// result and returns a 32-bit writeback value with a DONE or ERR pulse.
module core_fpu_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [2:0]   OP_SEL,
  input  logic [31:0]  SRC_A,
  input  logic [31:0]  SRC_B,
  output logic         STALL,
  output logic         DONE,
  output logic         ERR,
  output logic [31:0]  RESULT,
  output logic [31:0]  A_TDATA,
  output logic [31:0]  B_TDATA,
  output logic [7:0]   OP_TDATA,
  output logic [3:0]   A_TVALID,
  input  logic [3:0]   A_TREADY,
  output logic [3:0]   B_TVALID,
  input  logic [3:0]   B_TREADY,
  output logic [1:0]   OP_TVALID,
  input  logic [1:0]   OP_TREADY,
  input  logic [127:0] R_TDATA,
  input  logic [3:0]   R_TVALID,
  output logic [3:0]   R_TREADY
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {U_ADDSUB, U_MUL, U_DIV, U_COMP} unit_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t      state, state_n;
  unit_t       unit, unit_n, dec_unit;
  logic        a_vld, a_vld_n, b_vld, b_vld_n, op_vld, op_vld_n;
  logic        r_rdy, r_rdy_n;
  logic        stall, stall_n, done, done_n, err, err_n;
  logic [31:0] result, result_n, a_data, a_data_n, b_data, b_data_n;
  logic [7:0]  op_code, op_code_n, dec_op;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic        timeout_hit;

  logic [1:0]  sel;
  logic [3:0]  sel_1h;
  logic        a_rdy_sel, b_rdy_sel, op_rdy_sel, r_hit;
  logic [31:0] r_slice;

  assign sel         = unit;
  assign sel_1h      = 4'b0001 << sel;
  assign a_rdy_sel   = A_TREADY[sel];
  assign b_rdy_sel   = B_TREADY[sel];
  assign op_rdy_sel  = (unit == U_COMP) ? OP_TREADY[1] : OP_TREADY[0];
  assign r_hit       = r_rdy & R_TVALID[sel];
  assign r_slice     = R_TDATA[{sel, 5'd0} +: 32];
  assign cnt_inc     = cnt + 16'd1;
  assign timeout_hit = (cnt_inc == TO_LIM);

  // Decode OP_SEL into target unit and the opcode byte driven on OP_TDATA.
  always_comb begin
    dec_unit = U_ADDSUB;
    dec_op   = 8'h00;
    case (OP_SEL)
      3'd1: dec_op = 8'h01;
      3'd2: dec_unit = U_MUL;
      3'd3: dec_unit = U_DIV;
      3'd4: begin dec_unit = U_COMP; dec_op = 8'h14; end
      3'd5: begin dec_unit = U_COMP; dec_op = 8'h0C; end
      3'd6: begin dec_unit = U_COMP; dec_op = 8'h1C; end
      default: ;
    endcase
  end

  // Next-state logic: issue, per-channel handshake tracking, result capture, timeout.
  always_comb begin
    state_n   = state;
    unit_n    = unit;
    a_vld_n   = a_vld;
    b_vld_n   = b_vld;
    op_vld_n  = op_vld;
    r_rdy_n   = r_rdy;
    stall_n   = stall;
    done_n    = 1'b0;
    err_n     = 1'b0;
    result_n  = result;
    a_data_n  = a_data;
    b_data_n  = b_data;
    op_code_n = op_code;
    cnt_n     = cnt;
    case (state)
      S_IDLE: begin
        if (START) begin
          if (OP_SEL == 3'd7) begin
            err_n = 1'b1;
          end else begin
            unit_n    = dec_unit;
            a_data_n  = SRC_A;
            b_data_n  = SRC_B;
            op_code_n = dec_op;
            a_vld_n   = 1'b1;
            b_vld_n   = 1'b1;
            op_vld_n  = (dec_unit == U_ADDSUB) || (dec_unit == U_COMP);
            stall_n   = 1'b1;
            cnt_n     = 16'd1;
            state_n   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        a_vld_n  = a_vld & ~a_rdy_sel;
        b_vld_n  = b_vld & ~b_rdy_sel;
        op_vld_n = op_vld & ~op_rdy_sel;
        cnt_n    = cnt_inc;
        if (timeout_hit) begin
          a_vld_n  = 1'b0;
          b_vld_n  = 1'b0;
          op_vld_n = 1'b0;
          r_rdy_n  = 1'b0;
          err_n    = 1'b1;
          stall_n  = 1'b0;
          state_n  = S_IDLE;
        end else if (!a_vld_n && !b_vld_n && !op_vld_n) begin
          r_rdy_n = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving on the same cycle as the timeout still wins.
        if (r_hit) begin
          result_n = (unit == U_COMP) ? {31'b0, r_slice[0]} : r_slice;
          done_n   = 1'b1;
          stall_n  = 1'b0;
          r_rdy_n  = 1'b0;
          state_n  = S_IDLE;
        end else if (timeout_hit) begin
          r_rdy_n = 1'b0;
          err_n   = 1'b1;
          stall_n = 1'b0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      unit    <= U_ADDSUB;
      a_vld   <= 1'b0;
      b_vld   <= 1'b0;
      op_vld  <= 1'b0;
      r_rdy   <= 1'b0;
      stall   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      a_data  <= '0;
      b_data  <= '0;
      op_code <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      unit    <= unit_n;
      a_vld   <= a_vld_n;
      b_vld   <= b_vld_n;
      op_vld  <= op_vld_n;
      r_rdy   <= r_rdy_n;
      stall   <= stall_n;
      done    <= done_n;
      err     <= err_n;
      result  <= result_n;
      a_data  <= a_data_n;
      b_data  <= b_data_n;
      op_code <= op_code_n;
      cnt     <= cnt_n;
    end
  end

  assign A_TVALID  = a_vld ? sel_1h : '0;
  assign B_TVALID  = b_vld ? sel_1h : '0;
  assign R_TREADY  = r_rdy ? sel_1h : '0;
  assign OP_TVALID = !op_vld ? 2'b00 : (unit == U_COMP) ? 2'b10 : 2'b01;
  assign STALL     = stall;
  assign DONE      = done;
  assign ERR       = err;
  assign RESULT    = result;
  assign A_TDATA   = a_data;
  assign B_TDATA   = b_data;
  assign OP_TDATA  = op_code;

endmodule
